// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard and forwarding controller for the 5-stage pipeline.
//
// Keeps a shadow scoreboard of the E/M/W slots. Each slot records the
// destination register and its remaining Tnew. The controller compares the
// D-stage Tuse values against that scoreboard to produce the stall and the
// forwarding selects. It also owns the MDU occupancy counter. That counter
// holds MDU-class instructions in D while a mult/div is still running.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   D_ReadA1/2, Tuse1/2  source registers of D and when D needs them (3 = never)
//   D_WriteA, D_RegWrite destination of D and whether it writes the GRF
//   D_Tnew               Tnew of D at E entry
//   D_MDUClass           D uses the MDU
//   D_MDUStart, D_MDUDiv D starts an MDU op; that op is a divide
//   stall                freeze PC and F/D; bubble into D/E
//   Trans_grf_Sel1/2     D operand source: 0 GRF, 1 M_EResult, 2 E_Imm
//   Trans_ALUIn_Sel1/2   E operand source: 0 D/E reg, 1 M_EResult, 2 W_GRFWData
//   Trans_MemRD_Sel      M store-data source: 0 E/M reg, 1 W_GRFWData
//   MDUBusy              MDU occupied
//   stall_cnt            (HAZ_STATS_EN only) count of stalled clocks, wraps
//
// Build option: define HAZ_STATS_EN to add the stall_cnt output and counter.

module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_ReadA1,
    input  logic [4:0]  D_ReadA2,
    input  logic [1:0]  Tuse1,
    input  logic [1:0]  Tuse2,
    input  logic [4:0]  D_WriteA,
    input  logic        D_RegWrite,
    input  logic [1:0]  D_Tnew,
    input  logic        D_MDUClass,
    input  logic        D_MDUStart,
    input  logic        D_MDUDiv,
    output logic        stall,
    output logic [1:0]  Trans_grf_Sel1,
    output logic [1:0]  Trans_grf_Sel2,
    output logic [1:0]  Trans_ALUIn_Sel1,
    output logic [1:0]  Trans_ALUIn_Sel2,
    output logic [1:0]  Trans_MemRD_Sel,
    output logic        MDUBusy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef struct packed {
        logic       rw;
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic       start;
        logic       div;
    } slot_t;

    // E keeps the full slot. M and W keep only the fields that are still
    // consulted once an instruction has left E.
    slot_t       e_q, e_d;
    logic        m_rw_q, m_rw_d;
    logic [4:0]  m_wa_q, m_wa_d;
    logic [1:0]  m_tnew_q, m_tnew_d;
    logic [4:0]  m_ra2_q, m_ra2_d;
    logic        w_rw_q, w_rw_d;
    logic [4:0]  w_wa_q, w_wa_d;
    logic [3:0]  mdu_cnt_q, mdu_cnt_d;

    // $0 is never a producer, so it never stalls and never forwards.
    function automatic logic hit(input logic rw, input logic [4:0] wa, input logic [4:0] r);
        return rw && (wa == r) && (r != 5'd0);
    endfunction

    logic e_hit1, e_hit2, m_hit1, m_hit2;

    always_comb begin
        e_hit1  = hit(e_q.rw, e_q.wa, D_ReadA1);
        e_hit2  = hit(e_q.rw, e_q.wa, D_ReadA2);
        m_hit1  = hit(m_rw_q, m_wa_q, D_ReadA1);
        m_hit2  = hit(m_rw_q, m_wa_q, D_ReadA2);

        // E.start covers the cycle before the counter has been loaded.
        MDUBusy = (mdu_cnt_q != 4'd0) | e_q.start;

        stall = (e_hit1 && (Tuse1 < e_q.tnew)) ||
                (m_hit1 && (Tuse1 < m_tnew_q)) ||
                (e_hit2 && (Tuse2 < e_q.tnew)) ||
                (m_hit2 && (Tuse2 < m_tnew_q)) ||
                (D_MDUClass && MDUBusy);

        Trans_grf_Sel1 = 2'd0;
        if (e_hit1 && e_q.tnew == 2'd0)      Trans_grf_Sel1 = 2'd2;
        else if (m_hit1 && m_tnew_q == 2'd0) Trans_grf_Sel1 = 2'd1;

        Trans_grf_Sel2 = 2'd0;
        if (e_hit2 && e_q.tnew == 2'd0)      Trans_grf_Sel2 = 2'd2;
        else if (m_hit2 && m_tnew_q == 2'd0) Trans_grf_Sel2 = 2'd1;

        Trans_ALUIn_Sel1 = 2'd0;
        if (hit(m_rw_q, m_wa_q, e_q.ra1) && m_tnew_q == 2'd0) Trans_ALUIn_Sel1 = 2'd1;
        else if (hit(w_rw_q, w_wa_q, e_q.ra1))                Trans_ALUIn_Sel1 = 2'd2;

        Trans_ALUIn_Sel2 = 2'd0;
        if (hit(m_rw_q, m_wa_q, e_q.ra2) && m_tnew_q == 2'd0) Trans_ALUIn_Sel2 = 2'd1;
        else if (hit(w_rw_q, w_wa_q, e_q.ra2))                Trans_ALUIn_Sel2 = 2'd2;

        Trans_MemRD_Sel = {1'b0, hit(w_rw_q, w_wa_q, m_ra2_q)};
    end

    always_comb begin
        // A stall inserts an all-zero bubble. Its start bit is clear, so the
        // held D_MDUStart enters E exactly once, after the stall releases.
        e_d = '0;
        if (!stall) begin
            e_d.rw    = D_RegWrite;
            e_d.wa    = D_WriteA;
            e_d.tnew  = D_Tnew;
            e_d.ra1   = D_ReadA1;
            e_d.ra2   = D_ReadA2;
            e_d.start = D_MDUStart;
            e_d.div   = D_MDUDiv;
        end

        m_rw_d   = e_q.rw;
        m_wa_d   = e_q.wa;
        m_tnew_d = (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;
        m_ra2_d  = e_q.ra2;
        w_rw_d   = m_rw_q;
        w_wa_d   = m_wa_q;

        mdu_cnt_d = mdu_cnt_q;
        if (e_q.start)               mdu_cnt_d = e_q.div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        else if (mdu_cnt_q != 4'd0)  mdu_cnt_d = mdu_cnt_q - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q       <= '0;
            m_rw_q    <= 1'b0;
            m_wa_q    <= 5'd0;
            m_tnew_q  <= 2'd0;
            m_ra2_q   <= 5'd0;
            w_rw_q    <= 1'b0;
            w_wa_q    <= 5'd0;
            mdu_cnt_q <= 4'd0;
        end else begin
            e_q       <= e_d;
            m_rw_q    <= m_rw_d;
            m_wa_q    <= m_wa_d;
            m_tnew_q  <= m_tnew_d;
            m_ra2_q   <= m_ra2_d;
            w_rw_q    <= w_rw_d;
            w_wa_q    <= w_wa_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      stall_cnt_q <= 32'd0;
        else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
